// File: rtl/pc_gen_ras_if.sv
// Fetch PC generator bundle: branch/trap/predecode inputs toward the generator and
// PC/RAS/EPC outputs back to the fetch stage.
interface pc_gen_ras_if #(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 4
);
   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   logic              pc_write_en;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_target;
   logic              trap_valid;
   logic [ADDR_W-1:0] trap_pc;
   logic              call;
   logic              ret;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus_inc;
   logic [ADDR_W-1:0] ras_top;
   logic [CNT_W-1:0]  ras_count;
   logic              ras_empty;
   logic [ADDR_W-1:0] epc;

   modport master (
      output pc_write_en, redirect_valid, redirect_target, trap_valid, trap_pc, call, ret,
      input  pc, pc_plus_inc, ras_top, ras_count, ras_empty, epc
   );

   modport slave (
      input  pc_write_en, redirect_valid, redirect_target, trap_valid, trap_pc, call, ret,
      output pc, pc_plus_inc, ras_top, ras_count, ras_empty, epc
   );
endinterface

// File: rtl/pc_gen_ras.sv
// Fetch-stage next-PC generator: trap > redirect > stall > RAS return > sequential,
// with a circular return-address stack and EPC capture on trap.
module pc_gen_ras #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter logic [ADDR_W-1:0] TRAP_VEC  = 'h80,
   parameter int unsigned       INC       = 4,
   parameter int                RAS_DEPTH = 4
) (
   input logic         clk,
   input logic         reset,
   pc_gen_ras_if.slave bus
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] pcReg;
   logic [ADDR_W-1:0] epcReg;
   logic [ADDR_W-1:0] pcNext;
   logic [ADDR_W-1:0] pcPlusInc;
   logic [ADDR_W-1:0] rasTop;
   logic [ADDR_W-1:0] rasMem [RAS_DEPTH];
   logic [PTR_W-1:0]  topPtr;
   logic [CNT_W-1:0]  rasCount;
   logic              rasEmpty;
   logic              doPush;
   logic              doPop;
   logic              doReplace;
   logic              doClear;
   logic              capEpc;

   assign pcPlusInc = pcReg + ADDR_W'(INC);
   assign rasEmpty  = (rasCount == '0);
   assign rasTop    = rasEmpty ? '0 : rasMem[topPtr];

   always_comb begin
      pcNext    = pcPlusInc;
      doPush    = 1'b0;
      doPop     = 1'b0;
      doReplace = 1'b0;
      doClear   = 1'b0;
      capEpc    = 1'b0;
      if (bus.trap_valid) begin
         pcNext  = TRAP_VEC;
         doClear = 1'b1;
         capEpc  = 1'b1;
      end else if (bus.redirect_valid) begin
         pcNext = bus.redirect_target;
      end else if (!bus.pc_write_en) begin
         pcNext = pcReg;
      end else if (bus.ret && !rasEmpty) begin
         // call+ret on a non-empty stack swaps the top entry in place
         pcNext    = rasTop;
         doReplace = bus.call;
         doPop     = !bus.call;
      end else if (bus.call) begin
         doPush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcReg    <= RESET_VEC;
         epcReg   <= '0;
         topPtr   <= '0;
         rasCount <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) rasMem[i] <= '0;
      end else begin
         pcReg <= pcNext;
         if (capEpc) epcReg <= bus.trap_pc;
         if (doClear) begin
            rasCount <= '0;
         end else if (doPush) begin
            // full stack: pointer wraps onto the oldest entry, count saturates
            topPtr                      <= topPtr + PTR_W'(1);
            rasMem[topPtr + PTR_W'(1)]  <= pcPlusInc;
            if (rasCount != CNT_W'(RAS_DEPTH)) rasCount <= rasCount + CNT_W'(1);
         end else if (doPop) begin
            topPtr   <= topPtr - PTR_W'(1);
            rasCount <= rasCount - CNT_W'(1);
         end else if (doReplace) begin
            rasMem[topPtr] <= pcPlusInc;
         end
      end
   end

   assign bus.pc          = pcReg;
   assign bus.pc_plus_inc = pcPlusInc;
   assign bus.ras_top     = rasTop;
   assign bus.ras_count   = rasCount;
   assign bus.ras_empty   = rasEmpty;
   assign bus.epc         = epcReg;
endmodule

// File: tb/tb_pc_gen_ras.sv
// Bench for pc_gen_ras: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a queue-based model of the PC and return stack.
module tb_pc_gen_ras;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   int   nCompared   = 0;
   int   nMismatched = 0;
   bit   checkEn     = 1'b0;

   // model state
   logic [31:0] mPc  = '0;
   logic [31:0] mEpc = '0;
   logic [31:0] mq[$];

   pc_gen_ras_if #(.ADDR_W(32), .RAS_DEPTH(DEPTH)) bus ();

   pc_gen_ras #(.ADDR_W(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h80), .INC(4), .RAS_DEPTH(DEPTH))
      dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mPc  = 32'h0;
      mEpc = 32'h0;
      mq.delete();
   endtask

   task automatic modelPush(input logic [31:0] v);
      mq.push_back(v);
      if (mq.size() > DEPTH) void'(mq.pop_front());
   endtask

   // Applies the current inputs to the model as one clock edge.
   task automatic modelEdge();
      logic [31:0] seq;
      logic [31:0] t;
      seq = mPc + 32'd4;
      if (bus.trap_valid) begin
         mPc  = 32'h80;
         mEpc = bus.trap_pc;
         mq.delete();
      end else if (bus.redirect_valid) begin
         mPc = bus.redirect_target;
      end else if (bus.pc_write_en) begin
         if (bus.ret && mq.size() > 0) begin
            t = mq.pop_back();
            if (bus.call) modelPush(seq);
            mPc = t;
         end else begin
            if (bus.call) modelPush(seq);
            mPc = seq;
         end
      end
   endtask

   task automatic drive(input bit we, input bit rv, input logic [31:0] rt, input bit tv,
                        input logic [31:0] tp, input bit c, input bit r);
      bus.pc_write_en     = we;
      bus.redirect_valid  = rv;
      bus.redirect_target = rt;
      bus.trap_valid      = tv;
      bus.trap_pc         = tp;
      bus.call            = c;
      bus.ret             = r;
   endtask

   task automatic step();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic seqStep();
      drive(1, 0, 0, 0, 0, 0, 0);
      step();
   endtask

   task automatic redir(input logic [31:0] t);
      drive(1, 1, t, 0, 0, 0, 0);
      step();
   endtask

   task automatic callStep();
      drive(1, 0, 0, 0, 0, 1, 0);
      step();
   endtask

   task automatic retStep();
      drive(1, 0, 0, 0, 0, 0, 1);
      step();
   endtask

   always @(negedge clk) begin
      if (checkEn && !reset) begin
         chk("pc", bus.pc, mPc);
         chk("pc_plus_inc", bus.pc_plus_inc, mPc + 32'd4);
         chk("ras_top", bus.ras_top, (mq.size() == 0) ? 32'h0 : mq[$]);
         chk("ras_count", 32'(bus.ras_count), 32'(mq.size()));
         chk("ras_empty", 32'(bus.ras_empty), 32'(mq.size() == 0));
         chk("epc", bus.epc, mEpc);
      end
   end

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      modelReset();
      #1;
      chk("async_reset_pc", bus.pc, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkEn = 1'b1;
      chk("T1_pc_reset", bus.pc, 32'h0);

      // T1 sequential then stall
      seqStep(); chk("T1_pc4", bus.pc, 32'h4);
      seqStep(); chk("T1_pc8", bus.pc, 32'h8);
      seqStep(); chk("T1_pcC", bus.pc, 32'hC);
      drive(0, 0, 0, 0, 0, 0, 0);
      step(); step();
      chk("T1_stall", bus.pc, 32'hC);

      // T2 call then return
      redir(32'h100);
      callStep();
      chk("T2_pc", bus.pc, 32'h104);
      chk("T2_top", bus.ras_top, 32'h104);
      chk("T2_cnt", 32'(bus.ras_count), 32'd1);
      redir(32'h200);
      retStep();
      chk("T2_ret_pc", bus.pc, 32'h104);
      chk("T2_ret_cnt", 32'(bus.ras_count), 32'd0);
      chk("T2_empty", 32'(bus.ras_empty), 32'd1);

      // T3 overflow and underflow
      redir(32'h10);
      repeat (5) callStep();
      chk("T3_cnt_full", 32'(bus.ras_count), 32'd4);
      retStep(); chk("T3_r1", bus.pc, 32'h24);
      retStep(); chk("T3_r2", bus.pc, 32'h20);
      retStep(); chk("T3_r3", bus.pc, 32'h1C);
      retStep(); chk("T3_r4", bus.pc, 32'h18);
      retStep(); chk("T3_r5_seq", bus.pc, 32'h1C);
      chk("T3_cnt0", 32'(bus.ras_count), 32'd0);

      // T4 trap wins over everything
      callStep();
      drive(0, 1, 32'h999, 1, 32'h44, 0, 1);
      step();
      chk("T4_pc", bus.pc, 32'h80);
      chk("T4_epc", bus.epc, 32'h44);
      chk("T4_cnt", 32'(bus.ras_count), 32'd0);

      // T5 redirect ignores stall
      callStep();
      drive(0, 1, 32'h300, 0, 0, 0, 0);
      step();
      chk("T5_pc", bus.pc, 32'h300);
      chk("T5_top", bus.ras_top, 32'h84);
      chk("T5_cnt", 32'(bus.ras_count), 32'd1);

      // T6 call+ret swap, async reset, address wrap
      drive(1, 0, 0, 1, 32'h0, 0, 0);
      step();
      redir(32'h30); callStep();
      redir(32'h4C); callStep();
      redir(32'h60);
      drive(1, 0, 0, 0, 0, 1, 1);
      step();
      chk("T6_pc", bus.pc, 32'h50);
      chk("T6_top", bus.ras_top, 32'h64);
      chk("T6_cnt", 32'(bus.ras_count), 32'd2);
      #2;
      reset = 1'b1;
      modelReset();
      #1;
      chk("T6_rst_pc", bus.pc, 32'h0);
      chk("T6_rst_cnt", 32'(bus.ras_count), 32'd0);
      #1;
      reset = 1'b0;
      redir(32'hFFFF_FFFC);
      chk("T6_pc_plus_wrap", bus.pc_plus_inc, 32'h0);
      seqStep();
      chk("T6_wrap", bus.pc, 32'h0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                           : ($urandom & 32'h0000_0FFC);
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, tgt,
               $urandom_range(0, 31) == 0, $urandom, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 199) == 0) begin
            @(posedge clk);
            #3;
            reset = 1'b1;
            modelReset();
            #1;
            chk("rnd_rst_pc", bus.pc, 32'h0);
            #1;
            reset = 1'b0;
         end else begin
            step();
         end
      end

      checkEn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
